// File: rtl/ysyx_23060077_ifu_pcgen.sv
// ---------------------------------------------------------------------------
// ysyx_23060077_ifu_pcgen
//
// Fetch-side PC generator. It owns the architectural fetch PC and keeps one
// instruction fetch in flight at a time. Each fetched word goes to the IDU
// over a valid/ready handshake. An EXU redirect reloads the PC. A fetch that
// was already issued when the redirect arrived is marked stale and its
// response is thrown away.
//
// Ports:
//   clock, reset              : single clock, synchronous active-high reset
//   redirect_valid/_pc        : one-cycle redirect pulse and target from EXU
//   req_valid/ready/addr      : fetch request to the memory arbiter
//   rsp_valid/ready/data/err  : fetch response from the memory arbiter
//   inst_valid/ready          : instruction handshake towards the IDU
//   inst_pc, inst, inst_err   : instruction payload (PC, word, access fault)
// ---------------------------------------------------------------------------
module ysyx_23060077_ifu_pcgen #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h3000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [DATA_WIDTH-1:0] req_addr,
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  rsp_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_pc,
  output logic [DATA_WIDTH-1:0] inst,
  output logic                  inst_err
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [DATA_WIDTH-1:0]   pc_r;
  logic [DATA_WIDTH-1:0]   req_addr_r;
  logic                    kill_r;
  logic [DATA_WIDTH-1:0]   inst_r;
  logic [DATA_WIDTH-1:0]   inst_pc_r;
  logic                    inst_err_r;
  logic [DATA_WIDTH-1:0]   pc_inc_s;

  // Sequential fetch step; the addition wraps modulo 2^DATA_WIDTH.
  assign pc_inc_s = pc_r + {{(DATA_WIDTH-3){1'b0}}, 3'd4};

  assign req_addr = req_addr_r;
  assign inst_pc  = inst_pc_r;
  assign inst     = inst_r;
  assign inst_err = inst_err_r;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= BOOT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. A response that arrives together with a redirect, or
  // while the kill flag is set, belongs to a stale fetch and sends us back
  // to REQ.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      BOOT: begin
        state_nxt_s = REQ;
      end
      REQ: begin
        if (req_ready) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        if (rsp_valid) begin
          if (redirect_valid || kill_r) begin
            state_nxt_s = REQ;
          end else begin
            state_nxt_s = OUT;
          end
        end else begin
          state_nxt_s = WAIT;
        end
      end
      OUT: begin
        if (redirect_valid || inst_ready) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = OUT;
        end
      end
      default: begin
        state_nxt_s = BOOT;
      end
    endcase
  end

  // Output decode. Outputs depend only on the state register, so there is
  // no combinational path from any input.
  always_comb begin
    req_valid  = 1'b0;
    rsp_ready  = 1'b0;
    inst_valid = 1'b0;
    case (state_r)
      REQ:     req_valid  = 1'b1;
      WAIT:    rsp_ready  = 1'b1;
      OUT:     inst_valid = 1'b1;
      default: req_valid  = 1'b0;
    endcase
  end

  // PC, request address, kill flag and instruction buffer. A redirect beats
  // every other PC update. A request already in REQ is never retracted.
  // Instead, kill marks its response for dropping.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r       <= RESET_PC;
      req_addr_r <= RESET_PC;
      kill_r     <= 1'b0;
      inst_r     <= {DATA_WIDTH{1'b0}};
      inst_pc_r  <= {DATA_WIDTH{1'b0}};
      inst_err_r <= 1'b0;
    end else begin
      case (state_r)
        BOOT: begin
          req_addr_r <= pc_r;
        end
        REQ: begin
          if (redirect_valid) begin
            pc_r   <= redirect_pc;
            kill_r <= 1'b1;
          end
        end
        WAIT: begin
          if (rsp_valid) begin
            if (redirect_valid) begin
              pc_r       <= redirect_pc;
              req_addr_r <= redirect_pc;
              kill_r     <= 1'b0;
            end else if (kill_r) begin
              req_addr_r <= pc_r;
              kill_r     <= 1'b0;
            end else begin
              inst_r     <= rsp_data;
              inst_pc_r  <= req_addr_r;
              inst_err_r <= rsp_err;
            end
          end else if (redirect_valid) begin
            pc_r   <= redirect_pc;
            kill_r <= 1'b1;
          end
        end
        OUT: begin
          // When a redirect coincides with inst_ready, the transfer still
          // happens, but the redirect target replaces the pc+4 step.
          if (redirect_valid) begin
            pc_r       <= redirect_pc;
            req_addr_r <= redirect_pc;
          end else if (inst_ready) begin
            pc_r       <= pc_inc_s;
            req_addr_r <= pc_inc_s;
          end
        end
        default: begin
          kill_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ysyx_23060077_ifu_pcgen.md
Name: ysyx_23060077_ifu_pcgen

Overview:
Fetch-side consumer of the EXU redirect target (jump_pc); owns the architectural fetch PC.
Issues one instruction-fetch request at a time to the memory/LSU arbiter over a valid/ready request and response interface, then hands the fetched instruction to the IDU over valid/ready.
On a redirect (branch, jump, ecall, mret) it reloads the PC and discards any stale in-flight fetch.
It sits between the EXU redirect logic and the IDU, in front of the instruction memory port.

Parameters:
DATA_WIDTH, 32, width of PC, address and instruction
RESET_PC, 32'h3000_0000, first fetch address after reset

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
redirect_valid  input  1  one-cycle pulse from EXU; redirect_pc is a new fetch target
redirect_pc  input  DATA_WIDTH  redirect target (EXU jump_pc)
req_valid  output  1  fetch request valid
req_ready  input  1  memory accepts the request
req_addr  output  DATA_WIDTH  fetch address; stable while req_valid && !req_ready
rsp_valid  input  1  fetch response valid
rsp_ready  output  1  IFU can take a response
rsp_data  input  DATA_WIDTH  fetched instruction
rsp_err  input  1  bus error on the fetch
inst_valid  output  1  instruction valid to IDU
inst_ready  input  1  IDU accepts the instruction
inst_pc  output  DATA_WIDTH  PC of the instruction
inst  output  DATA_WIDTH  instruction word
inst_err  output  1  access fault flag travelling with the instruction

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high, sampled on the rising edge of clock.
- Internal state:
  - pc register: next address to fetch.
  - req_addr_r register: address of the outstanding request.
  - kill flag.
  - FSM with states BOOT, REQ, WAIT, OUT.
- Reset (effective the cycle after reset is sampled, and also when reset is asserted mid-operation):
  - Registers: state=BOOT, pc=RESET_PC, kill=0, req_addr_r=RESET_PC, inst/inst_pc=0, inst_err=0.
  - Outputs: req_valid=0, rsp_ready=0, inst_valid=0.
  - Any outstanding bus transaction is abandoned; the interconnect is reset together with this block.
- Outputs decode the FSM state directly (no combinational path from inputs):
  - req_valid = (state==REQ)
  - rsp_ready = (state==WAIT)
  - inst_valid = (state==OUT)
- BOOT: goes to REQ unconditionally after one cycle; req_addr_r is loaded from pc.
- REQ:
  - Holds req_valid with req_addr=req_addr_r.
  - On req_ready, goes to WAIT.
- WAIT, on rsp_valid:
  - kill=1: the response is dropped, kill is cleared, req_addr_r is loaded from pc, go to REQ.
  - kill=0: inst<=rsp_data, inst_pc<=req_addr_r, inst_err<=rsp_err, go to OUT.
- OUT:
  - On inst_ready: pc<=pc+4 (modulo 2^DATA_WIDTH; wraps with no fault), req_addr_r<=pc+4, go to REQ.
  - Otherwise hold inst/inst_pc/inst_err stable.
- Latency: minimum 3 cycles from the request handshake to inst_valid (REQ accept, WAIT with rsp, OUT). Back-to-back fetch throughput is 1 instruction per 3 cycles at best.
- Redirect handling: redirect_valid has priority over all PC updates; pc<=redirect_pc in every state except BOOT. Per state:
  - BOOT: ignored (EXU cannot be active).
  - REQ: kill<=1. The request is NOT retracted; req_addr stays stable until accepted. The FSM then follows the normal path, and the response is dropped in WAIT.
  - WAIT without rsp_valid: kill<=1.
  - WAIT with rsp_valid in the same cycle: the response is dropped, kill<=0, req_addr_r<=redirect_pc, go to REQ.
  - OUT: go to REQ with req_addr_r<=redirect_pc.
    - inst_valid drops next cycle.
    - If inst_ready was also high, that handshake still counts as a transfer, but the pc+4 update is suppressed. The IDU flushes on the same redirect.
- Back-to-back redirects while kill=1: the last redirect_pc wins; only one stale response is dropped, because there is at most 1 outstanding request.
- rsp_valid outside WAIT is illegal and ignored.
- redirect_pc is not alignment-checked here; misalignment faults belong to the EXU.

Test Plan:
1. Reset then idle memory:
   - Stimulus: req_ready=1, rsp returns 1 cycle later, inst_ready=1.
   - Required: req_addr sequence 0x3000_0000, 0x3000_0004, 0x3000_0008; inst_pc matches each; inst_valid never high during reset.
2. IDU backpressure:
   - Stimulus: hold inst_ready=0 for 5 cycles in OUT.
   - Required: inst and inst_pc are stable, no new req_valid; after release, next req_addr = inst_pc+4.
3. Redirect while in WAIT:
   - Stimulus: redirect_pc=0x3000_0100 at pc 0x3000_0008; the stale response arrives 2 cycles later.
   - Required: the stale response is dropped (inst_valid stays 0); next req_addr=0x3000_0100.
4. Redirect in REQ with req_ready=0:
   - Required: req_addr stays 0x3000_0004 until accepted, then its response is dropped; next req_addr=redirect_pc.
5. Redirect in the same cycle as rsp_valid, and redirect in OUT with inst_ready=1:
   - Required: both go straight to REQ at redirect_pc with no pc+4 step.
   - Also: two redirects (0x100, then 0x200) during one WAIT give a single drop and next fetch 0x200.
6. Reset asserted mid-WAIT, and error propagation:
   - Reset mid-WAIT: required state BOOT, all valid outputs 0, first fetch at RESET_PC.
   - Separately, rsp_err=1 on a response gives inst_err=1 for that instruction only.
